// File: rtl/bus_rv32_arbiter.sv
// Two-master round-robin arbiter for the rv32 peripheral bus with fixed read latency.
// Optional BUS_RV32_ARB_LOCK_EN adds m_lock_i so a locked owner keeps the bus.
module bus_rv32_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic [1:0]          m_req_i,
    input  logic [1:0]          m_we_i,
    input  logic [2*ADDR_W-1:0] m_addr_i,
    input  logic [2*DATA_W-1:0] m_wdata_i,
`ifdef BUS_RV32_ARB_LOCK_EN
    input  logic [1:0]          m_lock_i,
`endif
    output logic [1:0]          m_gnt_o,
    output logic [1:0]          m_rvalid_o,
    output logic [DATA_W-1:0]   m_rdata_o,
    output logic [ADDR_W-1:0]   address_o,
    output logic                we_o,
    output logic [DATA_W-1:0]   data_o,
    input  logic [DATA_W-1:0]   data_i,
    output logic                busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

    localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);

    state_t     state, state_nxt;
    logic [2:0] cnt;
    logic       last_grant;
    logic       locked;
    logic       win;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (|m_req_i) state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (we_o)                   state_nxt = S_IDLE;
                else if (READ_LATENCY == 1) state_nxt = S_RESP;
                else                        state_nxt = S_WAIT;
            end
            S_WAIT:   if (cnt == 3'd1) state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Winner selection: a locked owner that is still requesting beats round-robin.
    always_comb begin
        busy_o = (state != S_IDLE);
`ifdef BUS_RV32_ARB_LOCK_EN
        locked = m_lock_i[last_grant] & m_req_i[last_grant];
`else
        locked = 1'b0;
`endif
        if (locked)        win = last_grant;
        else if (&m_req_i) win = ~last_grant;
        else               win = m_req_i[1];
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            m_gnt_o    <= '0;
            m_rvalid_o <= '0;
            m_rdata_o  <= '0;
            address_o  <= '0;
            we_o       <= 1'b0;
            data_o     <= '0;
            cnt        <= '0;
            last_grant <= 1'b1;
        end else begin
            m_gnt_o    <= '0;
            m_rvalid_o <= '0;
            case (state)
                S_IDLE: if (|m_req_i) begin
                    m_gnt_o    <= win ? 2'b10 : 2'b01;
                    last_grant <= win;
                    we_o       <= m_we_i[win];
                    address_o  <= win ? m_addr_i[2*ADDR_W-1:ADDR_W]  : m_addr_i[ADDR_W-1:0];
                    data_o     <= win ? m_wdata_i[2*DATA_W-1:DATA_W] : m_wdata_i[DATA_W-1:0];
                end
                S_ACCESS: begin
                    we_o <= 1'b0;
                    cnt  <= LAT_LOAD;
                end
                S_WAIT:   cnt <= cnt - 3'd1;
                // rdata and rvalid become visible together in the following IDLE cycle.
                S_RESP: begin
                    m_rdata_o  <= data_i;
                    m_rvalid_o <= last_grant ? 2'b10 : 2'b01;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_rv32_arbiter.sv
// Directed + randomized checks of bus_rv32_arbiter against a transaction-level model.
module tb_bus_rv32_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RL = 3;
    localparam logic [31:0] KEY = 32'hA5A5_5A5A;

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b0;
    logic [1:0]    m_req_i = '0;
    logic [1:0]    m_we_i = '0;
    logic [2*AW-1:0] m_addr_i = '0;
    logic [2*DW-1:0] m_wdata_i = '0;
`ifdef BUS_RV32_ARB_LOCK_EN
    logic [1:0]    m_lock_i = '0;
`endif
    logic [1:0]    m_gnt_o, m_rvalid_o;
    logic [DW-1:0] m_rdata_o, data_o, data_i;
    logic [AW-1:0] address_o;
    logic          we_o, busy_o;

    int   vectors = 0;
    int   miscompares = 0;
    logic last = 1'b1;
    logic [1:0]  pend;
    logic [31:0] ra [2];
    logic [31:0] rd [2];
    logic        rw [2];

    always #5 clk_i = ~clk_i;

    // Slave returns a value derived from the address it is given.
    assign data_i = address_o ^ KEY;

    bus_rv32_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
`ifdef BUS_RV32_ARB_LOCK_EN
        .m_lock_i(m_lock_i),
`endif
        .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
        .address_o(address_o), .we_o(we_o), .data_o(data_o), .data_i(data_i),
        .busy_o(busy_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 64'(m_gnt_o), 0);
        chk({tag, "_rvalid"}, 64'(m_rvalid_o), 0);
        chk({tag, "_rdata"}, 64'(m_rdata_o), 0);
        chk({tag, "_addr"}, 64'(address_o), 0);
        chk({tag, "_we"}, 64'(we_o), 0);
        chk({tag, "_data"}, 64'(data_o), 0);
        chk({tag, "_busy"}, 64'(busy_o), 0);
    endtask

    // One arbitration round starting from IDLE: predicts winner, grant, and completion.
    task automatic run_txn(input logic [1:0] rq, input logic [1:0] wev,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1);
        logic w;
        logic [31:0] ea, ed;
        logic lk;
        lk = 1'b0;
`ifdef BUS_RV32_ARB_LOCK_EN
        lk = m_lock_i[last] && rq[last];
`endif
        if (lk)            w = last;
        else if (rq == 3)  w = ~last;
        else               w = rq[1];
        last = w;
        ea = w ? a1 : a0;
        ed = w ? d1 : d0;
        m_req_i = rq;
        m_we_i = wev;
        m_addr_i = {a1, a0};
        m_wdata_i = {d1, d0};
        tick();
        chk("gnt", 64'(m_gnt_o), w ? 64'd2 : 64'd1);
        chk("addr", 64'(address_o), 64'(ea));
        chk("we_access", 64'(we_o), 64'(wev[w]));
        chk("busy_access", 64'(busy_o), 1);
        chk("rvalid_access", 64'(m_rvalid_o), 0);
        if (wev[w]) chk("wdata", 64'(data_o), 64'(ed));
        m_req_i[w] = 1'b0;
        if (wev[w]) begin
            tick();
            chk("we_after", 64'(we_o), 0);
            chk("busy_after_wr", 64'(busy_o), 0);
            chk("gnt_after_wr", 64'(m_gnt_o), 0);
            chk("addr_hold", 64'(address_o), 64'(ea));
        end else begin
            for (int k = 0; k < RL; k++) begin
                tick();
                chk("rd_busy", 64'(busy_o), 1);
                chk("rd_we", 64'(we_o), 0);
                chk("rd_gnt", 64'(m_gnt_o), 0);
                chk("rd_rvalid_early", 64'(m_rvalid_o), 0);
            end
            tick();
            chk("rvalid", 64'(m_rvalid_o), w ? 64'd2 : 64'd1);
            chk("rdata", 64'(m_rdata_o), 64'(ea ^ KEY));
            chk("busy_rd_done", 64'(busy_o), 0);
            chk("addr_hold_rd", 64'(address_o), 64'(ea));
        end
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        chk_all_zero("reset");
        reset_n_i = 1'b1;
        tick();
        chk_all_zero("post_reset_idle");

        // Single write from master 0, single read from master 1
        run_txn(2'b01, 2'b01, 32'h9000_0010, 32'h0, 32'hDEAD_BEEF, 32'h0);
        run_txn(2'b10, 2'b00, 32'h0, 32'h9000_0004, 32'h0, 32'h0);

        // Continuous contention: alternation 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            run_txn(2'b11, 2'b11, 32'h100 + 32'(i), 32'h200 + 32'(i), 32'(i), 32'(i) + 32'h10);
            chk("alternate", 64'(last), 64'(i % 2));
        end
        m_req_i = '0;
        tick();

        // Master 1 requests in the middle of master 0's read
        m_req_i = 2'b01; m_we_i = 2'b10; m_addr_i = {32'h9000_0020, 32'h9000_0030};
        m_wdata_i = {32'hCAFE_F00D, 32'h0};
        tick();
        chk("mid_gnt0", 64'(m_gnt_o), 1);
        last = 1'b0;
        m_req_i = 2'b00;
        tick();
        tick();
        m_req_i = 2'b10;
        tick();
        chk("mid_no_gnt_resp", 64'(m_gnt_o), 0);
        tick();
        chk("mid_rvalid0", 64'(m_rvalid_o), 1);
        chk("mid_rdata", 64'(m_rdata_o), 64'(32'h9000_0030 ^ KEY));
        chk("mid_no_gnt_idle", 64'(m_gnt_o), 0);
        tick();
        chk("mid_gnt1", 64'(m_gnt_o), 2);
        chk("mid_we1", 64'(we_o), 1);
        chk("mid_data1", 64'(data_o), 64'(32'hCAFE_F00D));
        last = 1'b1;
        m_req_i = '0;
        tick();

        // Reset asserted during WAIT
        m_req_i = 2'b01; m_we_i = 2'b00; m_addr_i = {32'h0, 32'h9000_0040};
        tick();
        chk("rst_gnt", 64'(m_gnt_o), 1);
        m_req_i = '0;
        tick();
        chk("rst_in_wait_busy", 64'(busy_o), 1);
        #2 reset_n_i = 1'b0;
        #1 chk_all_zero("async_reset");
        last = 1'b1;
        @(posedge clk_i);
        #1 reset_n_i = 1'b1;
        for (int k = 0; k < RL + 2; k++) begin
            tick();
            chk("no_stale_rvalid", 64'(m_rvalid_o), 0);
        end
        run_txn(2'b11, 2'b11, 32'h300, 32'h400, 32'h1, 32'h2);
        chk("tie_after_reset", 64'(last), 0);
        m_req_i = '0;
        tick();

`ifdef BUS_RV32_ARB_LOCK_EN
        m_lock_i = 2'b01;
        for (int i = 0; i < 4; i++) begin
            run_txn(2'b11, 2'b11, 32'h500, 32'h600, 32'h5, 32'h6);
            chk("lock_owner", 64'(last), 0);
        end
        m_lock_i = 2'b00;
        run_txn(2'b11, 2'b11, 32'h500, 32'h600, 32'h5, 32'h6);
        chk("unlock_next", 64'(last), 1);
        m_req_i = '0;
        tick();
`endif

        // Randomized rounds; a losing master keeps its request and fields stable
        pend = '0;
        for (int it = 0; it < 40; it++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pend[m]) begin
                    ra[m] = $urandom;
                    rd[m] = $urandom;
                    rw[m] = 1'($urandom_range(0, 1));
                end
            end
            run_txn(2'($urandom_range(1, 3)) | pend, {rw[1], rw[0]}, ra[0], ra[1], rd[0], rd[1]);
            pend = m_req_i;
        end
        m_req_i = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
